design_04_arb: RTL

Round-robin arbiter and sequencer that shares one design_04 datapath between N requesters. It accepts an operand pair from one requester at a time, pulses the datapath start, waits for datapath valid, and returns the result tagged with the requester index. It sits between the requester fabric and a single design_04 instance; the datapath itself is unchanged.

---
 rtl/design_04_arb_pkg.sv | 16 +
 rtl/design_04_arb_if.sv | 34 +++
 rtl/design_04_rr_pick.sv | 32 +++
 rtl/design_04_arb.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/design_04_arb_pkg.sv
// Shared types and default widths for the design_04 round-robin arbiter/sequencer.
// The optional WAIT watchdog is enabled by defining DESIGN_04_ARB_TIMEOUT_EN.
package design_04_arb_pkg;

  localparam int DEF_W       = 20;
  localparam int DEF_N       = 4;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/design_04_arb_if.sv
// Requester, datapath and response signals of the design_04 arbiter in one bundle.
// The slave modport is the arbiter side; the master modport is the fabric/datapath side.
interface design_04_arb_if #(
  parameter int W   = design_04_arb_pkg::DEF_W,
  parameter int N   = design_04_arb_pkg::DEF_N,
  parameter int IDW = $clog2(N)
);

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           dp_start;
  logic [W-1:0]   dp_a;
  logic [W-1:0]   dp_b;
  logic           dp_valid;
  logic [W-1:0]   dp_y;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_y;
  logic [IDW-1:0] resp_id;
  logic           resp_err;

  modport master (
    output req_valid, req_a, req_b, dp_valid, dp_y, resp_ready,
    input  req_ready, dp_start, dp_a, dp_b, resp_valid, resp_y, resp_id, resp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, dp_valid, dp_y, resp_ready,
    output req_ready, dp_start, dp_a, dp_b, resp_valid, resp_y, resp_id, resp_err
  );

endinterface

// File: rtl/design_04_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping mod N.
module design_04_rr_pick
  import design_04_arb_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant_oh,
  output logic [IDW-1:0] grant_idx,
  output logic           any
);

  logic [IDW-1:0] idx;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = IDW'((int'(ptr) + i) % N);
      if (!any && req[idx]) begin
        any           = 1'b1;
        grant_idx     = idx;
        grant_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/design_04_arb.sv
// Round-robin arbiter/sequencer sharing one design_04 datapath between N requesters.
// Define DESIGN_04_ARB_TIMEOUT_EN to add a WAIT watchdog that returns resp_err=1 after TIMEOUT cycles.
module design_04_arb
  import design_04_arb_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int N       = DEF_N,
  parameter int IDW     = $clog2(N),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic           clk,
  input logic           rst,
  design_04_arb_if.slave bus
);

  if (N < 2 || N > 8 || TIMEOUT < 2) begin : g_bad_param
    $error("design_04_arb: N must be 2..8 and TIMEOUT at least 2");
  end

  arb_state_e     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] g_q;
  logic [W-1:0]   dp_a_q;
  logic [W-1:0]   dp_b_q;
  logic           dp_start_q;
  logic           resp_valid_q;
  logic [W-1:0]   resp_y_q;
  logic [IDW-1:0] resp_id_q;

  logic [N-1:0]   grant_oh;
  logic [IDW-1:0] grant_idx;
  logic           any_req;
  logic [IDW-1:0] ptr_next;

  logic [W-1:0]   a_arr [N];
  logic [W-1:0]   b_arr [N];

`ifdef DESIGN_04_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0]  wait_cnt;
  logic           resp_err_q;
`endif

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign a_arr[i] = bus.req_a[i*W +: W];
    assign b_arr[i] = bus.req_b[i*W +: W];
  end

  design_04_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  // Next search starts just past the requester that was last served.
  assign ptr_next = (g_q == IDW'(N - 1)) ? '0 : g_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      g_q          <= '0;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      dp_start_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_y_q     <= '0;
      resp_id_q    <= '0;
`ifdef DESIGN_04_ARB_TIMEOUT_EN
      wait_cnt     <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            dp_a_q     <= a_arr[grant_idx];
            dp_b_q     <= b_arr[grant_idx];
            g_q        <= grant_idx;
            dp_start_q <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          dp_start_q <= 1'b0;
`ifdef DESIGN_04_ARB_TIMEOUT_EN
          wait_cnt   <= '0;
`endif
          state      <= WAIT;
        end
        WAIT: begin
          if (bus.dp_valid) begin
            resp_y_q     <= bus.dp_y;
            resp_id_q    <= g_q;
            resp_valid_q <= 1'b1;
`ifdef DESIGN_04_ARB_TIMEOUT_EN
            resp_err_q   <= 1'b0;
`endif
            state        <= RESP;
          end
`ifdef DESIGN_04_ARB_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            resp_y_q     <= '0;
            resp_id_q    <= g_q;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            state        <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            ptr          <= ptr_next;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Accept strobe is only offered while idle, so a grant coincides with capture.
  assign bus.req_ready  = (state == IDLE) ? grant_oh : '0;
  assign bus.dp_start   = dp_start_q;
  assign bus.dp_a       = dp_a_q;
  assign bus.dp_b       = dp_b_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_y     = resp_y_q;
  assign bus.resp_id    = resp_id_q;
`ifdef DESIGN_04_ARB_TIMEOUT_EN
  assign bus.resp_err   = resp_err_q;
`else
  assign bus.resp_err   = 1'b0;
`endif

endmodule
